// File: rtl/cas_pkg.sv
`default_nettype none
// ============================================================================
// Module : cas_pkg
// Brief  : Shared timing thresholds, status codes and pulse classes for the
//          cassette recorder.
// Rev    : 1.0 - initial release
// ============================================================================
package cas_pkg;

  typedef enum logic [1:0] {
    P_NONE  = 2'd0,
    P_SHORT = 2'd1,
    P_LONG  = 2'd2,
    P_GAP   = 2'd3
  } pulse_t;

  localparam int c_cnt_w = 17;

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_armed     = 3'd1;
  localparam logic [2:0] c_st_frame     = 3'd2;
  localparam logic [2:0] c_st_motor_off = 3'd3;
  localparam logic [2:0] c_st_overflow  = 3'd4;

  function automatic int t_min(input int clk_hz);
    return clk_hz / 4800;
  endfunction

  function automatic int t_split(input int clk_hz);
    return clk_hz / 1600;
  endfunction

  function automatic int t_max(input int clk_hz);
    return clk_hz / 800;
  endfunction

  function automatic int t_gap(input int clk_hz);
    return clk_hz / 200;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cas_fsk_demod.sv
`default_nettype none
// ============================================================================
// Module : cas_fsk_demod
// Brief  : Synchronises the FSK tape signal, measures edge-to-edge periods and
//          turns SHORT/LONG pulse pairs into bits.
// Rev    : 1.0 - initial release
// ============================================================================
module cas_fsk_demod
  import cas_pkg::*;
#(
  parameter int CLK_HZ = 21_330_000
) (
  input  logic clk,
  input  logic reset,
  input  logic tap_out,
  output logic bit_valid,
  output logic bit_val,
  output logic resync,
  output logic pair_err
);

  localparam logic [c_cnt_w-1:0] c_t_min   = c_cnt_w'(t_min(CLK_HZ));
  localparam logic [c_cnt_w-1:0] c_t_split = c_cnt_w'(t_split(CLK_HZ));
  localparam logic [c_cnt_w-1:0] c_t_max   = c_cnt_w'(t_max(CLK_HZ));
  localparam logic [c_cnt_w-1:0] c_t_gap   = c_cnt_w'(t_gap(CLK_HZ));

  typedef enum logic [0:0] {B_IDLE = 1'b0, B_HALF = 1'b1} bit_st_t;

  logic [1:0]         r_sync;
  logic               r_tap_d;
  logic [c_cnt_w-1:0] r_cnt;
  bit_st_t            r_bst;
  logic               w_edge;
  pulse_t             w_class;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= 2'b00;
      r_tap_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], tap_out};
      r_tap_d <= r_sync[1];
    end
  end

  assign w_edge = r_sync[1] & ~r_tap_d;

  // A glitch edge leaves the counter running so the real period is kept.
  always_comb begin
    w_class = P_NONE;
    if (w_edge) begin
      if (r_cnt < c_t_min)        w_class = P_NONE;
      else if (r_cnt < c_t_split) w_class = P_SHORT;
      else if (r_cnt <= c_t_max)  w_class = P_LONG;
      else                        w_class = P_GAP;
    end else if (r_cnt == c_t_gap) begin
      w_class = P_GAP;
    end
  end

  // Restart at 1 so the value seen on the next edge equals the period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_edge && (r_cnt >= c_t_min)) begin
      r_cnt <= c_cnt_w'(1);
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bst     <= B_IDLE;
      bit_valid <= 1'b0;
      bit_val   <= 1'b0;
      resync    <= 1'b0;
      pair_err  <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      bit_val   <= 1'b0;
      resync    <= 1'b0;
      pair_err  <= 1'b0;
      case (w_class)
        P_SHORT: begin
          if (r_bst == B_IDLE) begin
            r_bst <= B_HALF;
          end else begin
            bit_valid <= 1'b1;
            bit_val   <= 1'b1;
            r_bst     <= B_IDLE;
          end
        end
        P_LONG: begin
          if (r_bst == B_IDLE) begin
            bit_valid <= 1'b1;
          end else begin
            pair_err <= 1'b1;
            r_bst    <= B_IDLE;
          end
        end
        P_GAP: begin
          r_bst  <= B_IDLE;
          resync <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cas_recorder.sv
`default_nettype none
// ============================================================================
// Module : cas_recorder
// Brief  : Frames decoded tape bits into bytes, buffers them and writes them
//          into the SDRAM CAS region during free SDRAM slots.
// Rev    : 1.0 - initial release
// ============================================================================
module cas_recorder
  import cas_pkg::*;
#(
  parameter int CLK_HZ     = 21_330_000,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 21
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              record,
  input  logic              motor,
  input  logic              tap_out,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [7:0]        sdram_dout,
  output logic              sdram_we,
  input  logic              sdram_available,
  input  logic              sdram_ready,
  output logic [ADDR_W-1:0] byte_count,
  output logic [2:0]        status,
  output logic              frame_err
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {F_OFF = 2'd0, F_HUNT = 2'd1, F_DATA = 2'd2, F_STOP = 2'd3} frame_st_t;
  typedef enum logic [0:0] {W_IDLE = 1'b0, W_WAIT = 1'b1} wr_st_t;

  logic             w_bit_valid, w_bit_val, w_resync, w_pair_err;
  logic             r_record_d, w_arm;
  frame_st_t        r_fst;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic             r_stop1, r_push, r_bad_stop;
  logic [7:0]       r_push_data;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [c_ptr_w:0] r_wr_ptr, r_rd_ptr;
  logic             w_empty, w_full, w_pop, w_push_ok;
  wr_st_t           r_wst;
  logic             r_overflow, r_end;

  cas_fsk_demod #(.CLK_HZ(CLK_HZ)) u_demod (
    .clk       (clk),
    .reset     (reset),
    .tap_out   (tap_out),
    .bit_valid (w_bit_valid),
    .bit_val   (w_bit_val),
    .resync    (w_resync),
    .pair_err  (w_pair_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_record_d <= 1'b0;
    else       r_record_d <= record;
  end

  assign w_arm = record & ~r_record_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fst       <= F_OFF;
      r_shift     <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_stop1     <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= 8'h00;
      r_bad_stop  <= 1'b0;
    end else begin
      r_push     <= 1'b0;
      r_bad_stop <= 1'b0;
      if (!record || !motor) begin
        r_fst <= F_OFF;
      end else begin
        case (r_fst)
          F_OFF: r_fst <= F_HUNT;
          F_HUNT: begin
            if (w_bit_valid && !w_bit_val) begin
              r_fst     <= F_DATA;
              r_bit_cnt <= 3'd0;
            end
          end
          F_DATA: begin
            if (w_resync) begin
              r_fst <= F_HUNT;
            end else if (w_bit_valid) begin
              r_shift   <= {w_bit_val, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == 3'd7) begin
                r_fst   <= F_STOP;
                r_stop1 <= 1'b0;
              end
            end
          end
          F_STOP: begin
            if (w_resync) begin
              r_fst <= F_HUNT;
            end else if (w_bit_valid) begin
              if (!w_bit_val) begin
                r_bad_stop <= 1'b1;
                r_fst      <= F_HUNT;
              end else if (r_stop1) begin
                r_push      <= 1'b1;
                r_push_data <= r_shift;
                r_fst       <= F_HUNT;
              end else begin
                r_stop1 <= 1'b1;
              end
            end
          end
          default: r_fst <= F_OFF;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                  frame_err <= 1'b0;
    else if (w_arm)                                             frame_err <= 1'b0;
    else if (r_bad_stop || (w_pair_err && (r_fst != F_OFF)))    frame_err <= 1'b1;
  end

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
  assign w_pop     = (r_wst == W_WAIT) && sdram_ready;
  assign w_push_ok = r_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push_ok && !w_arm) r_mem[r_wr_ptr[c_ptr_w-1:0]] <= r_push_data;
  end

  // Arming empties the buffer and wins over a push in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_arm) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wst      <= W_IDLE;
      sdram_we   <= 1'b0;
      sdram_dout <= 8'h00;
      sdram_addr <= '0;
      byte_count <= '0;
      r_overflow <= 1'b0;
      r_end      <= 1'b0;
    end else begin
      sdram_we <= 1'b0;
      if (w_arm) begin
        r_wst      <= W_IDLE;
        sdram_addr <= '0;
        byte_count <= '0;
        r_overflow <= 1'b0;
        r_end      <= 1'b0;
      end else begin
        if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
        case (r_wst)
          W_IDLE: begin
            if (!w_empty && sdram_available && !r_end) begin
              sdram_we   <= 1'b1;
              sdram_dout <= r_mem[r_rd_ptr[c_ptr_w-1:0]];
              r_wst      <= W_WAIT;
            end
          end
          W_WAIT: begin
            if (sdram_ready) begin
              r_wst <= W_IDLE;
              // The last address of the region is final: stop and flag it.
              if (sdram_addr == '1) begin
                r_end      <= 1'b1;
                r_overflow <= 1'b1;
              end else begin
                sdram_addr <= sdram_addr + 1'b1;
              end
              if (byte_count != '1) byte_count <= byte_count + 1'b1;
            end
          end
          default: r_wst <= W_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     status <= c_st_idle;
    else if (r_overflow)                           status <= c_st_overflow;
    else if (!record)                              status <= c_st_idle;
    else if (!motor)                               status <= c_st_motor_off;
    else if ((r_fst == F_DATA) || (r_fst == F_STOP)) status <= c_st_frame;
    else                                           status <= c_st_armed;
  end

endmodule
`default_nettype wire

// File: tb/tb_cas_recorder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_cas_recorder
// Brief  : Self-checking bench for cas_recorder with a scaled cassette clock.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_cas_recorder;

  localparam int CLK_HZ     = 120_000;
  localparam int ADDR_W     = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int P_S        = CLK_HZ / 2400;
  localparam int P_L        = CLK_HZ / 1200;
  localparam int SILENCE    = CLK_HZ / 150;

  logic              clk = 1'b0;
  logic              reset, record, motor, tap_out;
  logic              sdram_available, sdram_ready;
  logic [ADDR_W-1:0] sdram_addr, byte_count;
  logic [7:0]        sdram_dout;
  logic              sdram_we, frame_err;
  logic [2:0]        status;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          rsp_cnt  = 0;
  logic        ready_en = 1'b1;
  int          base     = 0;
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [7:0]        wr_data_q[$];
  logic [7:0]        exp_q[$];

  cas_recorder #(.CLK_HZ(CLK_HZ), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .record          (record),
    .motor           (motor),
    .tap_out         (tap_out),
    .sdram_addr      (sdram_addr),
    .sdram_dout      (sdram_dout),
    .sdram_we        (sdram_we),
    .sdram_available (sdram_available),
    .sdram_ready     (sdram_ready),
    .byte_count      (byte_count),
    .status          (status),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  // SDRAM model: logs each request and answers ready three cycles later.
  always @(negedge clk) begin
    sdram_ready = 1'b0;
    if (reset) begin
      rsp_cnt = 0;
    end else begin
      if (rsp_cnt > 0) begin
        rsp_cnt = rsp_cnt - 1;
        if (rsp_cnt == 0 && ready_en) sdram_ready = 1'b1;
      end
      if (sdram_we) begin
        wr_addr_q.push_back(sdram_addr);
        wr_data_q.push_back(sdram_dout);
        rsp_cnt = 3;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got t=%0t expected earlier finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_period(input int p, input bit glitch);
    if (glitch) begin
      tap_out = 1'b1; wait_n(12);
      tap_out = 1'b0; wait_n(8);
      tap_out = 1'b1; wait_n(5);
      tap_out = 1'b0; wait_n(p - 25);
    end else begin
      tap_out = 1'b1; wait_n(p / 2);
      tap_out = 1'b0; wait_n(p - p / 2);
    end
  endtask

  task automatic send_bit(input bit b, input bit glitch);
    if (b) begin
      send_period(P_S, glitch);
      send_period(P_S, glitch);
    end else begin
      send_period(P_L, glitch);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int lead, input bit glitch, input bit bad_stop);
    repeat (lead) send_bit(1'b1, glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
    send_bit(!bad_stop, glitch);
    send_bit(1'b1, glitch);
  endtask

  // Closing edge ends the last period, then silence lets the decoder resync.
  task automatic tail();
    tap_out = 1'b1; wait_n(P_S / 2);
    tap_out = 1'b0; wait_n(SILENCE);
  endtask

  task automatic arm();
    record = 1'b0;
    motor  = 1'b1;
    wait_n(3);
    record = 1'b1;
    wait_n(3);
    base = wr_data_q.size();
    exp_q.delete();
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && (wr_data_q.size() - base) < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; record = 1'b0; motor = 1'b0; tap_out = 1'b0; sdram_available = 1'b0;
    wait_n(5);
    n_checks++; if (sdram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", sdram_we); end
    n_checks++; if (sdram_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", sdram_addr); end
    n_checks++; if (sdram_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", sdram_dout); end
    n_checks++; if (byte_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", byte_count); end
    n_checks++; if (status !== 3'd0) begin n_fail++; $display("FAIL reset_status: got %0d expected 0", status); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    reset = 1'b0;
    wait_n(3);
    n_checks++; if (status !== 3'd0) begin n_fail++; $display("FAIL reset_idle: got %0d expected 0", status); end
  endtask

  task automatic test_byte55();
    arm();
    sdram_available = 1'b1;
    send_frame(8'h55, 8, 1'b0, 1'b0);
    tail();
    wait_writes(1, 200);
    n_checks++; if (wr_data_q.size() - base !== 1) begin n_fail++; $display("FAIL b55_writes: got %0d expected 1", wr_data_q.size() - base); end
    else begin
      n_checks++; if (wr_data_q[base] !== 8'h55) begin n_fail++; $display("FAIL b55_data: got %h expected 55", wr_data_q[base]); end
      n_checks++; if (wr_addr_q[base] !== '0) begin n_fail++; $display("FAIL b55_addr: got %0d expected 0", wr_addr_q[base]); end
    end
    n_checks++; if (byte_count !== 3'd1) begin n_fail++; $display("FAIL b55_count: got %0d expected 1", byte_count); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL b55_ferr: got %b expected 0", frame_err); end
    n_checks++; if (status !== 3'd1) begin n_fail++; $display("FAIL b55_status: got %0d expected 1", status); end
    motor = 1'b0; wait_n(3);
    n_checks++; if (status !== 3'd3) begin n_fail++; $display("FAIL motor_off_status: got %0d expected 3", status); end
    record = 1'b0; wait_n(3);
    n_checks++; if (status !== 3'd0) begin n_fail++; $display("FAIL rec_off_status: got %0d expected 0", status); end
  endtask

  task automatic test_back_to_back();
    arm();
    sdram_available = 1'b0;
    send_frame(8'hA3, 8, 1'b0, 1'b0);
    send_frame(8'h00, 8, 1'b0, 1'b0);
    tail();
    n_checks++; if (wr_data_q.size() - base !== 0) begin n_fail++; $display("FAIL b2b_held: got %0d writes expected 0", wr_data_q.size() - base); end
    n_checks++; if (status !== 3'd1) begin n_fail++; $display("FAIL b2b_status: got %0d expected 1", status); end
    sdram_available = 1'b1;
    wait_writes(2, 200);
    wait_n(20);
    exp_q = '{8'hA3, 8'h00};
    n_checks++; if (wr_data_q.size() - base !== 2) begin n_fail++; $display("FAIL b2b_writes: got %0d expected 2", wr_data_q.size() - base); end
    else for (int i = 0; i < 2; i++) begin
      n_checks++; if (wr_data_q[base+i] !== exp_q[i] || wr_addr_q[base+i] !== ADDR_W'(i)) begin
        n_fail++; $display("FAIL b2b_write%0d: got %h@%0d expected %h@%0d", i, wr_data_q[base+i], wr_addr_q[base+i], exp_q[i], i);
      end
    end
    n_checks++; if (byte_count !== 3'd2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", byte_count); end
  endtask

  task automatic test_bad_stop();
    arm();
    sdram_available = 1'b1;
    send_frame(8'h12, 2, 1'b0, 1'b1);
    send_frame(8'h34, 2, 1'b0, 1'b0);
    tail();
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL bad_stop_ferr: got %b expected 1", frame_err); end
    n_checks++; if (wr_data_q.size() - base !== 1) begin n_fail++; $display("FAIL bad_stop_writes: got %0d expected 1", wr_data_q.size() - base); end
    else begin
      n_checks++; if (wr_data_q[base] !== 8'h34 || wr_addr_q[base] !== '0) begin
        n_fail++; $display("FAIL bad_stop_next: got %h@%0d expected 34@0", wr_data_q[base], wr_addr_q[base]);
      end
    end
  endtask

  task automatic test_glitch();
    arm();
    sdram_available = 1'b1;
    send_frame(8'hC9, 2, 1'b1, 1'b0);
    tail();
    n_checks++; if (wr_data_q.size() - base !== 1) begin n_fail++; $display("FAIL glitch_writes: got %0d expected 1", wr_data_q.size() - base); end
    else begin
      n_checks++; if (wr_data_q[base] !== 8'hC9) begin n_fail++; $display("FAIL glitch_data: got %h expected c9", wr_data_q[base]); end
    end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_ferr: got %b expected 0", frame_err); end
  endtask

  task automatic test_gap();
    arm();
    sdram_available = 1'b1;
    repeat (2) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    n_checks++; if (status !== 3'd2) begin n_fail++; $display("FAIL gap_in_frame: got %0d expected 2", status); end
    wait_n(SILENCE);
    n_checks++; if (status !== 3'd1) begin n_fail++; $display("FAIL gap_hunt: got %0d expected 1", status); end
    send_frame(8'h5A, 2, 1'b0, 1'b0);
    tail();
    n_checks++; if (wr_data_q.size() - base !== 1) begin n_fail++; $display("FAIL gap_writes: got %0d expected 1", wr_data_q.size() - base); end
    else begin
      n_checks++; if (wr_data_q[base] !== 8'h5A || wr_addr_q[base] !== '0) begin
        n_fail++; $display("FAIL gap_next: got %h@%0d expected 5a@0", wr_data_q[base], wr_addr_q[base]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    arm();
    sdram_available = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1, 1'b0, 1'b0);
    end
    tail();
    n_checks++; if (status !== 3'd4) begin n_fail++; $display("FAIL ovf_status: got %0d expected 4", status); end
    sdram_available = 1'b1;
    wait_writes(FIFO_DEPTH, 200);
    wait_n(40);
    n_checks++; if (wr_data_q.size() - base !== FIFO_DEPTH) begin n_fail++; $display("FAIL ovf_writes: got %0d expected %0d", wr_data_q.size() - base, FIFO_DEPTH); end
    else for (int i = 0; i < FIFO_DEPTH; i++) begin
      n_checks++; if (wr_data_q[base+i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_data%0d: got %h expected %h", i, wr_data_q[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_end_of_region();
    logic [7:0] b;
    int n_exp;
    arm();
    sdram_available = 1'b1;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1, 1'b0, 1'b0);
    end
    tail();
    n_exp = 1 << ADDR_W;
    n_checks++; if (wr_data_q.size() - base !== n_exp) begin n_fail++; $display("FAIL eor_writes: got %0d expected %0d", wr_data_q.size() - base, n_exp); end
    else for (int i = 0; i < n_exp; i++) begin
      n_checks++; if (wr_data_q[base+i] !== exp_q[i] || wr_addr_q[base+i] !== ADDR_W'(i)) begin
        n_fail++; $display("FAIL eor_write%0d: got %h@%0d expected %h@%0d", i, wr_data_q[base+i], wr_addr_q[base+i], exp_q[i], i);
      end
    end
    n_checks++; if (status !== 3'd4) begin n_fail++; $display("FAIL eor_status: got %0d expected 4", status); end
    n_checks++; if (sdram_addr !== '1) begin n_fail++; $display("FAIL eor_addr: got %0d expected %0d", sdram_addr, n_exp - 1); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int n;
    arm();
    sdram_available = 1'b1;
    n = $urandom_range(2, 4);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, $urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'b0);
    end
    tail();
    n_checks++; if (wr_data_q.size() - base !== n) begin n_fail++; $display("FAIL rnd_writes: got %0d expected %0d", wr_data_q.size() - base, n); end
    else for (int i = 0; i < n; i++) begin
      n_checks++; if (wr_data_q[base+i] !== exp_q[i] || wr_addr_q[base+i] !== ADDR_W'(i)) begin
        n_fail++; $display("FAIL rnd_write%0d: got %h@%0d expected %h@%0d", i, wr_data_q[base+i], wr_addr_q[base+i], exp_q[i], i);
      end
    end
    n_checks++; if (byte_count !== ADDR_W'(n)) begin n_fail++; $display("FAIL rnd_count: got %0d expected %0d", byte_count, n); end
  endtask

  task automatic test_async_reset();
    arm();
    sdram_available = 1'b1;
    ready_en = 1'b1;
    send_frame(8'h81, 1, 1'b0, 1'b0);
    tail();
    ready_en = 1'b0;
    send_frame(8'h7E, 1, 1'b0, 1'b0);
    tail();
    wait_writes(2, 200);
    n_checks++; if (byte_count !== 3'd1) begin n_fail++; $display("FAIL rst_pre_count: got %0d expected 1", byte_count); end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (sdram_we !== 1'b0) begin n_fail++; $display("FAIL rst_async_we: got %b expected 0", sdram_we); end
    n_checks++; if (byte_count !== '0) begin n_fail++; $display("FAIL rst_async_count: got %0d expected 0", byte_count); end
    n_checks++; if (status !== 3'd0) begin n_fail++; $display("FAIL rst_async_status: got %0d expected 0", status); end
    wait_n(3);
    reset = 1'b0;
    ready_en = 1'b1;
    wait_n(3);
  endtask

  initial begin
    test_reset();
    test_byte55();
    test_back_to_back();
    test_bad_stop();
    test_glitch();
    test_gap();
    test_overflow();
    test_end_of_region();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
